// File: rtl/clk_ratio_meas.sv
// -----------------------------------------------------------------------------
// clk_ratio_meas
// Divided-clock ratio monitor. Samples a divided clock as data, measures its
// period (rise to rise) and high time in i_clk cycles, and reports lock once
// consecutive measurements agree. It also reports loss of clock when no rising
// edge arrives before the period counter saturates.
//
// Optional build macro:
//   CLK_RATIO_MEAS_SYNC_EN - inserts a 2-flop synchronizer ahead of the sample
//                            flop so i_div_clk may be asynchronous to i_clk
//                            (+2 cycles latency, +/-1 cycle measurement jitter).
//
// Parameters:
//   RATIO_WIDTH - width of period/high counters (max ratio 2^RATIO_WIDTH-2)
//   LOCK_CNT    - consecutive matching measurements needed for lock (1..15)
//
// Ports:
//   i_clk      in   source clock, rising edge
//   i_rst_n    in   asynchronous active-low reset
//   i_div_clk  in   divided clock under measurement
//   o_ratio    out  last measured period in i_clk cycles
//   o_high_cnt out  high samples in the last measured period
//   o_valid    out  one-cycle pulse when o_ratio/o_high_cnt update
//   o_locked   out  LOCK_CNT consecutive equal measurements seen
//   o_timeout  out  no rising edge for 2^RATIO_WIDTH-1 cycles; sticky until valid
// -----------------------------------------------------------------------------
module clk_ratio_meas #(
   parameter int RATIO_WIDTH = 8,
   parameter int LOCK_CNT    = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_div_clk,
   output logic [RATIO_WIDTH-1:0] o_ratio,
   output logic [RATIO_WIDTH-1:0] o_high_cnt,
   output logic                   o_valid,
   output logic                   o_locked,
   output logic                   o_timeout
);

   localparam logic [RATIO_WIDTH-1:0] ALL_ONES = '1;
   localparam logic [3:0]             LOCK_THR = 4'(LOCK_CNT);

   typedef enum logic {
      ACQ  = 1'b0,
      MEAS = 1'b1
   } state_t;

   function automatic logic [RATIO_WIDTH-1:0] sat_inc(input logic [RATIO_WIDTH-1:0] v);
      return (v == ALL_ONES) ? v : v + 1'b1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   logic                   s_p0;
   logic                   s_p1;
   logic                   s_p2;
   logic                   rise_p2;
   logic [RATIO_WIDTH-1:0] pcnt;
   logic [RATIO_WIDTH-1:0] hcnt;
   logic [3:0]             mcnt;
   logic [3:0]             mcnt_inc;
   logic                   first;
   state_t                 state;

   // ---- stage 0: sample i_div_clk ----
`ifdef CLK_RATIO_MEAS_SYNC_EN
   logic sync1;
   logic sync2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         s_p0  <= 1'b0;
      end else begin
         sync1 <= i_div_clk;
         sync2 <= sync1;
         s_p0  <= sync2;
      end
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_p0 <= 1'b0;
      end else begin
         s_p0 <= i_div_clk;
      end
   end
`endif

   // ---- stage 1/2: delayed sample and registered edge detect ----
   // s_p2 travels with rise_p2 so the high counter sees the sample that
   // belongs to the same cycle as the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_p1    <= 1'b0;
         s_p2    <= 1'b0;
         rise_p2 <= 1'b0;
      end else begin
         s_p1    <= s_p0;
         s_p2    <= s_p0;
         rise_p2 <= s_p0 & ~s_p1;
      end
   end

   // ---- stage 2: period and high-time counters ----
   // Loading 1 on the edge makes the value seen at the next edge equal the
   // number of cycles in the period, including the edge cycle itself.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pcnt <= '0;
         hcnt <= '0;
      end else if (rise_p2) begin
         pcnt <= {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
         hcnt <= {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         pcnt <= sat_inc(pcnt);
         if (s_p2) begin
            hcnt <= sat_inc(hcnt);
         end
      end
   end

   assign mcnt_inc = sat_inc4(mcnt);

   // ---- stage 3: measurement FSM and registered outputs ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ACQ;
         mcnt       <= 4'd0;
         first      <= 1'b0;
         o_ratio    <= '0;
         o_high_cnt <= '0;
         o_valid    <= 1'b0;
         o_locked   <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            ACQ: begin
               // The first edge only opens a period; nothing to report yet.
               if (rise_p2) begin
                  state <= MEAS;
                  first <= 1'b1;
               end
            end
            MEAS: begin
               // An edge coinciding with saturation still counts as a
               // measurement of an all-ones period.
               if (rise_p2) begin
                  o_ratio    <= pcnt;
                  o_high_cnt <= hcnt;
                  o_valid    <= 1'b1;
                  o_timeout  <= 1'b0;
                  first      <= 1'b0;
                  if (!first && (pcnt == o_ratio)) begin
                     mcnt <= mcnt_inc;
                     if (mcnt_inc >= LOCK_THR) begin
                        o_locked <= 1'b1;
                     end
                  end else begin
                     mcnt     <= 4'd0;
                     o_locked <= 1'b0;
                  end
               end else if (pcnt == ALL_ONES) begin
                  o_timeout <= 1'b1;
                  o_locked  <= 1'b0;
                  mcnt      <= 4'd0;
                  state     <= ACQ;
               end
            end
            default: state <= ACQ;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_ratio_meas.sv
// -----------------------------------------------------------------------------
// tb_clk_ratio_meas
// Scoreboard bench for clk_ratio_meas. A reference model looks at the stream
// of divided-clock samples, finds rising edges, and derives each expected
// measurement (period, high samples, lock, timeout) from those edges. Expected
// events are queued with the cycle they should appear; a monitor pops and
// compares whenever the DUT pulses o_valid or raises o_timeout.
// -----------------------------------------------------------------------------
module tb_clk_ratio_meas;

   localparam int RW   = 8;
   localparam int LOCK = 3;
   localparam int SAT  = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          div_clk = 1'b0;
   logic [RW-1:0] ratio;
   logic [RW-1:0] high_cnt;
   logic          valid;
   logic          locked;
   logic          timeout;

   clk_ratio_meas #(.RATIO_WIDTH(RW), .LOCK_CNT(LOCK)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_div_clk  (div_clk),
      .o_ratio    (ratio),
      .o_high_cnt (high_cnt),
      .o_valid    (valid),
      .o_locked   (locked),
      .o_timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_tmo;
      int ratio;
      int high;
      bit locked;
      bit timeout;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_prev;
   bit m_acq;
   int m_last;
   int m_highs;
   int m_ratio;
   int m_high;
   int m_run;      // length of the current run of equal measurements

   always @(posedge clk) begin
      bit   b;
      bit   rise;
      int   per;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         m_prev  = 1'b0;
         m_acq   = 1'b1;
         m_last  = 0;
         m_highs = 0;
         m_ratio = 0;
         m_high  = 0;
         m_run   = 0;
      end else begin
         b      = div_clk;
         rise   = b && !m_prev;
         m_prev = b;
         if (m_acq) begin
            if (rise) begin
               m_acq   = 1'b0;
               m_last  = cyc;
               m_highs = 1;
            end
         end else if (rise) begin
            per = cyc - m_last;
            if (m_run > 0 && per == m_ratio) m_run++;
            else m_run = 1;
            m_ratio   = per;
            m_high    = m_highs;
            e.is_tmo  = 1'b0;
            e.ratio   = per;
            e.high    = m_highs;
            e.locked  = (m_run > LOCK);
            e.timeout = 1'b0;
            e.cyc     = cyc + 2;
            q.push_back(e);
            m_last  = cyc;
            m_highs = 1;
         end else begin
            if (b) m_highs++;
            if (cyc - m_last >= SAT) begin
               m_run     = 0;
               m_acq     = 1'b1;
               e.is_tmo  = 1'b1;
               e.ratio   = m_ratio;
               e.high    = m_high;
               e.locked  = 1'b0;
               e.timeout = 1'b1;
               e.cyc     = cyc + 2;
               q.push_back(e);
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit tmo_prev = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (valid || (timeout && !tmo_prev)) begin
            if (q.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = q.pop_front();
               check("event_kind", int'(!valid), int'(e.is_tmo));
               check("event_cycle", cyc, e.cyc);
               check("ratio", int'(ratio), e.ratio);
               check("high_cnt", int'(high_cnt), e.high);
               check("locked", int'(locked), int'(e.locked));
               check("timeout", int'(timeout), int'(e.timeout));
            end
         end
         tmo_prev = timeout;
      end else begin
         tmo_prev = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_half(input bit v);
      @(clk);
      #1 div_clk = v;
   endtask

   // ratio in i_clk cycles; high_half = high time in half cycles
   task automatic drive_wave(input int r, input int high_half, input int periods);
      for (int p = 0; p < periods; p++)
         for (int h = 0; h < 2 * r; h++)
            drive_half(h < high_half);
   endtask

   task automatic hold_level(input bit v, input int cycles);
      for (int h = 0; h < 2 * cycles; h++) drive_half(v);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ratio"}, int'(ratio), 0);
      check({tag, "_high_cnt"}, int'(high_cnt), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_timeout"}, int'(timeout), 0);
   endtask

   initial begin
      int r;
      int h;
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;

      drive_wave(4, 4, 8);        // ratio 4, 50% duty
      drive_wave(5, 5, 8);        // ratio 5, negedge-extended high
      drive_wave(4, 4, 6);
      drive_wave(6, 6, 8);        // switch 4 -> 6 while locked
      hold_level(1'b0, 300);      // loss of clock
      drive_wave(3, 3, 6);        // restart
      drive_wave(2, 2, 8);        // minimum ratio
      drive_wave(254, 254, 3);    // largest ratio without saturation
      drive_wave(255, 200, 3);    // edge coincides with saturation

      repeat (25) begin
         r = $urandom_range(20, 2);
         h = $urandom_range(2 * r - 2, 2);
         n = $urandom_range(8, 1);
         drive_wave(r, h, n);
      end

      // reset mid-period while locked
      drive_wave(4, 4, 6);
      hold_level(1'b1, 1);
      #1 rst_n = 1'b0;
      q.delete();
      #1 check_all_zero("midreset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      drive_wave(4, 4, 6);

      hold_level(1'b0, 10);
      check("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
